ctu_sync_pulse_gen: RTL and testbench

Generates the global cmp-domain sync pulses `ctu_jbus_rx_sync`, `ctu_jbus_tx_sync` and `ctu_dram_tx_sync` that feed the CTU sync header and cluster sync distribution. Two programmable modulo counters track jbus and dram clock periods in cmp cycles, and a start/warm-up/run state machine sequences the counters. A req/ack handshake swaps in new clock ratios only at a common period boundary, so downstream pipes never see a truncated period.

---
 rtl/ctu_sync_pkg.sv | 52 +++++
 rtl/ctu_sync_pulse_gen_if.sv | 30 +++
 rtl/ctu_sync_divcnt.sv | 49 ++++
 rtl/ctu_sync_pulse_gen.sv | 145 ++++++++++++++
 tb/tb_ctu_sync_pulse_gen.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ctu_sync_pkg.sv
// Shared constants, state encoding and config payload for the CTU sync pulse generator.
package ctu_sync_pkg;

  localparam int unsigned RW  = 5;
  localparam int unsigned WCW = 3;
  localparam int unsigned SW  = 2;

  localparam logic [RW-1:0]  DEF_DIV  = RW'(4);
  localparam logic [RW-1:0]  DEF_RXO  = RW'(0);
  localparam logic [RW-1:0]  DEF_TXO  = RW'(2);
  localparam logic [RW-1:0]  MIN_DIV  = RW'(2);
  localparam logic [WCW-1:0] WARM_CYC = WCW'(7);

  typedef enum logic [SW-1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } sync_state_e;

  // One complete set of clock-ratio values as loaded into the active registers.
  typedef struct packed {
    logic [RW-1:0] jdiv;
    logic [RW-1:0] ddiv;
    logic [RW-1:0] rxo;
    logic [RW-1:0] txo;
  } sync_cfg_t;

  // A ratio below the minimum cannot form a period; raise it to the minimum.
  function automatic logic [RW-1:0] clamp_div(input logic [RW-1:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  // An offset outside the period would never match; pin it to the last phase.
  function automatic logic [RW-1:0] clamp_ofs(input logic [RW-1:0] ofs,
                                               input logic [RW-1:0] div);
    return (ofs >= div) ? (div - RW'(1)) : ofs;
  endfunction

  // Legalise a raw request into the values that will actually be loaded.
  function automatic sync_cfg_t load_cfg(input logic [RW-1:0] jd,
                                         input logic [RW-1:0] dd,
                                         input logic [RW-1:0] ro,
                                         input logic [RW-1:0] to);
    sync_cfg_t c;
    c.jdiv = clamp_div(jd);
    c.ddiv = clamp_div(dd);
    c.rxo  = clamp_ofs(ro, c.jdiv);
    c.txo  = clamp_ofs(to, c.jdiv);
    return c;
  endfunction

endpackage

// File: rtl/ctu_sync_pulse_gen_if.sv
// Control, config handshake and sync pulse bundle of the CTU sync pulse generator.
interface ctu_sync_pulse_gen_if
  import ctu_sync_pkg::*;
();

  logic          start_clk;
  logic [RW-1:0] jbus_div;
  logic [RW-1:0] dram_div;
  logic [RW-1:0] rx_ofs;
  logic [RW-1:0] tx_ofs;
  logic          cfg_req;
  logic          cfg_ack;
  logic          ctu_jbus_rx_sync;
  logic          ctu_jbus_tx_sync;
  logic          ctu_dram_tx_sync;
  logic          sync_run;

  // Controller side: sequences the generator and requests ratio changes.
  modport master (
    output start_clk, jbus_div, dram_div, rx_ofs, tx_ofs, cfg_req,
    input  cfg_ack, ctu_jbus_rx_sync, ctu_jbus_tx_sync, ctu_dram_tx_sync, sync_run
  );

  // Generator side.
  modport slave (
    input  start_clk, jbus_div, dram_div, rx_ofs, tx_ofs, cfg_req,
    output cfg_ack, ctu_jbus_rx_sync, ctu_jbus_tx_sync, ctu_dram_tx_sync, sync_run
  );

endinterface

// File: rtl/ctu_sync_divcnt.sv
// Modulo-div phase counter with a registered last-phase flag.
module ctu_sync_divcnt
  import ctu_sync_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [RW-1:0] div,
  output logic [RW-1:0] cnt,
  output logic          last
);

  logic [RW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  // Next phase; div only changes together with clr, so last can be precomputed.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (clr) begin
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (en) begin
      if (last_q) begin
        cnt_d  = '0;
        last_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + RW'(1);
        last_d = (cnt_d == (div - RW'(1)));
      end
    end
  end

  // Phase and last-phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = last_q;

endmodule

// File: rtl/ctu_sync_pulse_gen.sv
// Global cmp-domain jbus rx/tx and dram sync pulse generator with ratio-swap handshake.
module ctu_sync_pulse_gen
  import ctu_sync_pkg::*;
(
  input  logic                 cmp_clk,
  input  logic                 rst,
  ctu_sync_pulse_gen_if.slave  bus
);

  localparam logic [SW-1:0] S_IDLE = ST_IDLE;
  localparam logic [SW-1:0] S_WARM = ST_WARM;
  localparam logic [SW-1:0] S_RUN  = ST_RUN;

  logic [SW-1:0]  state_q, state_d;
  logic [WCW-1:0] warm_q, warm_d;
  logic [RW-1:0]  jdiv_q, jdiv_d;
  logic [RW-1:0]  ddiv_q, ddiv_d;
  logic [RW-1:0]  rxo_q, rxo_d;
  logic [RW-1:0]  txo_q, txo_d;
  logic           cfg_ack_q, cfg_ack_d;
  logic           rx_q, rx_d;
  logic           tx_q, tx_d;
  logic           dram_q, dram_d;
  logic           run_q, run_d;

  logic [RW-1:0]  jcnt, dcnt;
  logic           jlast, dlast;
  logic           acc_c, cnt_clr_c, cnt_en_c, pulse_en_c;
  sync_cfg_t      cfg_in_c;

  // Legalised view of the requested ratios.
  always_comb begin
    cfg_in_c = load_cfg(bus.jbus_div, bus.dram_div, bus.rx_ofs, bus.tx_ofs);
  end

  // Accept a request in IDLE at once, otherwise only where both periods end together.
  always_comb begin
    acc_c      = bus.cfg_req && !cfg_ack_q &&
                 ((state_q == S_IDLE) || (jlast && dlast));
    cnt_clr_c  = (state_q == S_IDLE) || !bus.start_clk || acc_c;
    cnt_en_c   = (state_q != S_IDLE);
    pulse_en_c = (state_q == S_RUN) && bus.start_clk;
  end

  ctu_sync_divcnt u_jcnt (
    .clk  (cmp_clk),
    .rst  (rst),
    .clr  (cnt_clr_c),
    .en   (cnt_en_c),
    .div  (jdiv_q),
    .cnt  (jcnt),
    .last (jlast)
  );

  ctu_sync_divcnt u_dcnt (
    .clk  (cmp_clk),
    .rst  (rst),
    .clr  (cnt_clr_c),
    .en   (cnt_en_c),
    .div  (ddiv_q),
    .cnt  (dcnt),
    .last (dlast)
  );

  // Start / warm-up / run sequencing; dropping start_clk wins from any state.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      S_IDLE: begin
        warm_d = '0;
        if (bus.start_clk) state_d = S_WARM;
      end
      S_WARM: begin
        if (warm_q == WARM_CYC) state_d = S_RUN;
        else                    warm_d  = warm_q + WCW'(1);
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (!bus.start_clk) begin
      state_d = S_IDLE;
      warm_d  = '0;
    end
  end

  // Active ratio registers swap only on an accepted request.
  always_comb begin
    jdiv_d    = jdiv_q;
    ddiv_d    = ddiv_q;
    rxo_d     = rxo_q;
    txo_d     = txo_q;
    cfg_ack_d = acc_c;
    if (acc_c) begin
      jdiv_d = cfg_in_c.jdiv;
      ddiv_d = cfg_in_c.ddiv;
      rxo_d  = cfg_in_c.rxo;
      txo_d  = cfg_in_c.txo;
    end
  end

  // Pulses fire one cycle after the phase match, only while running.
  always_comb begin
    rx_d   = pulse_en_c && (jcnt == rxo_q);
    tx_d   = pulse_en_c && (jcnt == txo_q);
    dram_d = pulse_en_c && dlast;
    run_d  = (state_d == S_RUN);
  end

  // State, config and output registers.
  always_ff @(posedge cmp_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      warm_q    <= '0;
      jdiv_q    <= DEF_DIV;
      ddiv_q    <= DEF_DIV;
      rxo_q     <= DEF_RXO;
      txo_q     <= DEF_TXO;
      cfg_ack_q <= 1'b0;
      rx_q      <= 1'b0;
      tx_q      <= 1'b0;
      dram_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      jdiv_q    <= jdiv_d;
      ddiv_q    <= ddiv_d;
      rxo_q     <= rxo_d;
      txo_q     <= txo_d;
      cfg_ack_q <= cfg_ack_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      dram_q    <= dram_d;
      run_q     <= run_d;
    end
  end

  assign bus.cfg_ack          = cfg_ack_q;
  assign bus.ctu_jbus_rx_sync = rx_q;
  assign bus.ctu_jbus_tx_sync = tx_q;
  assign bus.ctu_dram_tx_sync = dram_q;
  assign bus.sync_run         = run_q;

endmodule

// File: tb/tb_ctu_sync_pulse_gen.sv
// Directed self-checking bench for ctu_sync_pulse_gen.
module tb_ctu_sync_pulse_gen;
  import ctu_sync_pkg::*;

  logic cmp_clk;
  logic rst;
  int   errors;
  int   checks;

  ctu_sync_pulse_gen_if bus_if ();

  ctu_sync_pulse_gen dut (
    .cmp_clk (cmp_clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  initial cmp_clk = 1'b0;
  always #5 cmp_clk = ~cmp_clk;

  task automatic tick();
    @(posedge cmp_clk);
    #1;
  endtask

  // Observed outputs packed as {sync_run, rx, tx, dram, cfg_ack}.
  function automatic logic [4:0] obs_vec();
    return {bus_if.sync_run, bus_if.ctu_jbus_rx_sync, bus_if.ctu_jbus_tx_sync,
            bus_if.ctu_dram_tx_sync, bus_if.cfg_ack};
  endfunction

  // Expected outputs k cycles after start_clk rises from IDLE: 8 WARM cycles,
  // RUN from k=9, counters at phase (k-1) mod div, pulses one cycle after match.
  function automatic logic [4:0] exp_vec(int k, int j, int d, int r, int t);
    logic run, rx, tx, dr;
    run = (k >= 9);
    rx  = (k >= 10) && (((k - 2) % j) == r);
    tx  = (k >= 10) && (((k - 2) % j) == t);
    dr  = (k >= 10) && (((k - 2) % d) == (d - 1));
    return {run, rx, tx, dr, 1'b0};
  endfunction

  task automatic set_cfg(int jd, int dd, int ro, int to);
    bus_if.jbus_div = RW'(jd);
    bus_if.dram_div = RW'(dd);
    bus_if.rx_ofs   = RW'(ro);
    bus_if.tx_ofs   = RW'(to);
  endtask

  task automatic test_reset();
    logic [4:0] o;
    rst              = 1'b1;
    bus_if.start_clk = 1'b0;
    bus_if.cfg_req   = 1'b0;
    set_cfg(4, 4, 0, 2);
    for (int i = 0; i < 2; i++) begin
      tick();
      o = obs_vec();
      checks++;
      if (o !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, o, 5'b00000);
      end
    end
    rst = 1'b0;
    tick();
    o = obs_vec();
    checks++;
    if (o !== 5'b00000) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=%b", o, 5'b00000);
    end
  endtask

  task automatic test_default_run();
    logic [4:0] o, e;
    bus_if.start_clk = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      o = obs_vec();
      e = exp_vec(k, 4, 4, 0, 2);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL default_run k=%0d got=%b exp=%b", k, o, e);
      end
    end
  endtask

  task automatic test_ratio_swap();
    logic [4:0] o, e;
    int lat;
    lat = 0;
    set_cfg(6, 4, 0, 2);
    bus_if.cfg_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_if.cfg_ack === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus_if.cfg_req = 1'b0;
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL swap_ack_latency got=%0d exp=%0d (0 = timeout)", lat, 4);
    end
    o = obs_vec();
    checks++;
    if (o !== 5'b10011) begin
      errors++;
      $display("FAIL swap_ack_cycle got=%b exp=%b", o, 5'b10011);
    end
    for (int m = 1; m <= 18; m++) begin
      tick();
      o = obs_vec();
      e = {1'b1, ((m - 1) % 6) == 0, ((m - 1) % 6) == 2, ((m - 1) % 4) == 3, 1'b0};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL swap_run m=%0d got=%b exp=%b", m, o, e);
      end
    end
  endtask

  task automatic test_start_drop();
    logic [4:0] o, e;
    bus_if.start_clk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      o = obs_vec();
      checks++;
      if (o !== 5'b00000) begin
        errors++;
        $display("FAIL drop_idle cyc=%0d got=%b exp=%b", i, o, 5'b00000);
      end
    end
    bus_if.start_clk = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      o = obs_vec();
      e = exp_vec(k, 6, 4, 0, 2);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL drop_restart k=%0d got=%b exp=%b", k, o, e);
      end
    end
  endtask

  task automatic test_idle_cfg_clamp();
    logic [4:0] o, e;
    bus_if.start_clk = 1'b0;
    tick();
    set_cfg(1, 4, 0, 9);
    bus_if.cfg_req = 1'b1;
    tick();
    o = obs_vec();
    checks++;
    if (o !== 5'b00001) begin
      errors++;
      $display("FAIL idle_cfg_ack got=%b exp=%b", o, 5'b00001);
    end
    tick();
    o = obs_vec();
    checks++;
    if (o !== 5'b00000) begin
      errors++;
      $display("FAIL idle_cfg_no_double got=%b exp=%b", o, 5'b00000);
    end
    bus_if.cfg_req   = 1'b0;
    bus_if.start_clk = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      o = obs_vec();
      e = exp_vec(k, 2, 4, 0, 1);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL clamp_run k=%0d got=%b exp=%b", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] o, e;
    set_cfg(6, 3, 1, 1);
    bus_if.cfg_req = 1'b1;
    rst            = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      o = obs_vec();
      checks++;
      if (o !== 5'b00000) begin
        errors++;
        $display("FAIL rst_mid cyc=%0d got=%b exp=%b", i, o, 5'b00000);
      end
    end
    rst            = 1'b0;
    bus_if.cfg_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      o = obs_vec();
      e = exp_vec(k, 4, 4, 0, 2);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_defaults k=%0d got=%b exp=%b", k, o, e);
      end
    end
  endtask

  task automatic test_coincident();
    logic [4:0] o, e;
    bus_if.start_clk = 1'b0;
    tick();
    set_cfg(5, 4, 3, 3);
    bus_if.cfg_req = 1'b1;
    tick();
    o = obs_vec();
    checks++;
    if (o !== 5'b00001) begin
      errors++;
      $display("FAIL coinc_ack got=%b exp=%b", o, 5'b00001);
    end
    bus_if.cfg_req   = 1'b0;
    bus_if.start_clk = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      o = obs_vec();
      e = exp_vec(k, 5, 4, 3, 3);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL coinc_run k=%0d got=%b exp=%b", k, o, e);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst              = 1'b1;
    bus_if.start_clk = 1'b0;
    bus_if.cfg_req   = 1'b0;
    set_cfg(4, 4, 0, 2);
    test_reset();
    test_default_run();
    test_ratio_swap();
    test_start_drop();
    test_idle_cfg_clamp();
    test_reset_mid_run();
    test_coincident();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
